// File: rtl/accelbrot_com_pkg.sv
// Shared types and helpers for the accelbrot command/result path FIFOs.
// The status struct packs into the host status-register bit layout.
package accelbrot_com_pkg;

  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_status_t;

endpackage

// File: rtl/accelbrot_com_fifo_level.sv
// Occupancy tracker: level, full/empty, programmable almost flags and high-watermark.
// All outputs are registered from next_stored; thresholds act at the next edge.
module accelbrot_com_fifo_level
  import accelbrot_com_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = fifo_cw(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [CW-1:0] afull_th,
  input  logic [CW-1:0] aempty_th,
  input  logic          wm_clr,
  output logic [CW-1:0] stored,
  output logic          r_not_full,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [CW-1:0] watermark
);

  logic [CW-1:0] next_stored;
  fifo_status_t  status_d;
  fifo_status_t  status_q;

  always_comb begin
    next_stored = stored;
    if (flush) begin
      next_stored = '0;
    end else if (push && !pop) begin
      next_stored = stored + CW'(1);
    end else if (pop && !push) begin
      next_stored = stored - CW'(1);
    end
  end

  always_comb begin
    status_d.full   = (next_stored == CW'(DEPTH));
    status_d.empty  = (next_stored == '0);
    status_d.afull  = (next_stored >= afull_th);
    status_d.aempty = (next_stored < aempty_th);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stored     <= '0;
      r_not_full <= 1'b0;
      status_q   <= '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};
      watermark  <= '0;
    end else begin
      stored     <= next_stored;
      r_not_full <= (next_stored < CW'(DEPTH));
      status_q   <= status_d;
      // Clear reloads the current level rather than zero, so the mark stays meaningful.
      if (wm_clr || (next_stored > watermark)) begin
        watermark <= next_stored;
      end
    end
  end

  assign full   = status_q.full;
  assign empty  = status_q.empty;
  assign afull  = status_q.afull;
  assign aempty = status_q.aempty;

endmodule

// File: rtl/accelbrot_com_reg_fifo_prog.sv
// Shift-register FIFO with programmable almost flags, flush and watermark; 1-cycle write-to-read.
// Valid/ready both sides; no write-through when full, and no handshake during flush.
module accelbrot_com_reg_fifo_prog
  import accelbrot_com_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int CW         = fifo_cw(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [CW-1:0]         afull_th,
  input  logic [CW-1:0]         aempty_th,
  input  logic                  wm_clr,
  output logic                  wr_ready,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         stored,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [CW-1:0]         watermark
);

  logic [DEPTH*DATA_WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [CW-1:0]               wr_idx;
  logic                        r_not_full;
  logic                        push, pop;

  assign wr_ready = r_not_full & ~flush;
  assign rd_valid = vld_q[0] & ~flush;
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = mem_q[DATA_WIDTH-1:0];

  // Vacated top slots shift in zeros, which keeps rd_data at zero when empty.
  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    wr_idx = stored;
    if (pop) begin
      mem_d  = mem_q >> DATA_WIDTH;
      vld_d  = vld_q >> 1;
      wr_idx = stored - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          mem_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
          vld_d[i]                          = 1'b1;
        end
      end
    end
    if (flush) begin
      mem_d = '0;
      vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q <= '0;
      vld_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
    end
  end

  accelbrot_com_fifo_level #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_level (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .afull_th   (afull_th),
    .aempty_th  (aempty_th),
    .wm_clr     (wm_clr),
    .stored     (stored),
    .r_not_full (r_not_full),
    .full       (full),
    .empty      (empty),
    .afull      (afull),
    .aempty     (aempty),
    .watermark  (watermark)
  );

endmodule

// File: tb/tb_accelbrot_com_reg_fifo_prog.sv
// Directed vector bench for accelbrot_com_reg_fifo_prog at DATA_WIDTH=8, DEPTH=4.
// Each vector holds one cycle of inputs and the outputs expected just after that edge.
module tb_accelbrot_com_reg_fifo_prog;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] afull_th = 3'd3;
  logic [CW-1:0] aempty_th = 3'd1;
  logic          wm_clr = 1'b0;
  logic          wr_ready;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] stored;
  logic          full, empty, afull, aempty;
  logic [CW-1:0] watermark;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accelbrot_com_reg_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .afull_th(afull_th), .aempty_th(aempty_th),
    .wm_clr(wm_clr), .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .stored(stored),
    .full(full), .empty(empty), .afull(afull), .aempty(aempty), .watermark(watermark)
  );

  typedef struct {
    logic          rs, fl, wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic [CW-1:0] aft, aet;
    logic          wc;
    logic [19:0]   exp;  // {wr_ready, rd_valid, rd_data, stored, full, empty, afull, aempty, watermark}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic rs, fl, wv, input logic [DW-1:0] wd, input logic rr,
                             input logic [CW-1:0] aft, aet, input logic wc,
                             input logic wrdy, rvld, input logic [DW-1:0] rdat,
                             input logic [CW-1:0] st, input logic fu, em, af, ae,
                             input logic [CW-1:0] wm);
    vec_t t;
    t.rs = rs; t.fl = fl; t.wv = wv; t.wd = wd; t.rr = rr;
    t.aft = aft; t.aet = aet; t.wc = wc;
    t.exp = {wrdy, rvld, rdat, st, fu, em, af, ae, wm};
    return t;
  endfunction

  function automatic logic [19:0] actual();
    return {wr_ready, rd_valid, rd_data, stored, full, empty, afull, aempty, watermark};
  endfunction

  task automatic apply(input vec_t t, input int idx);
    logic [19:0] a;
    @(negedge clk);
    rstn = t.rs; flush = t.fl; wr_valid = t.wv; wr_data = t.wd; rd_ready = t.rr;
    afull_th = t.aft; aempty_th = t.aet; wm_clr = t.wc;
    @(posedge clk);
    #1;
    a = actual();
    n_vec++;
    if (a !== t.exp) begin
      n_err++;
      $display("FAIL vec%0d: got %h want %h (wrdy,rvld,rdat,st,full,empty,af,ae,wm)", idx, a, t.exp);
    end
  endtask

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // rs fl wv wd    rr aft   aet   wc | wrdy rvld rdat st  fu em af ae wm
    // reset, release
    vq.push_back(v(0,0,0,8'h00,0,3'd3,3'd1,0, 0,0,8'h00,3'd0,0,1,0,1,3'd0));
    vq.push_back(v(0,0,0,8'h00,0,3'd3,3'd1,0, 0,0,8'h00,3'd0,0,1,0,1,3'd0));
    vq.push_back(v(1,0,0,8'h00,0,3'd3,3'd1,0, 1,0,8'h00,3'd0,0,1,0,1,3'd0));
    // fill to full
    vq.push_back(v(1,0,1,8'h11,0,3'd3,3'd1,0, 1,1,8'h11,3'd1,0,0,0,0,3'd1));
    vq.push_back(v(1,0,1,8'h22,0,3'd3,3'd1,0, 1,1,8'h11,3'd2,0,0,0,0,3'd2));
    vq.push_back(v(1,0,1,8'h33,0,3'd3,3'd1,0, 1,1,8'h11,3'd3,0,0,1,0,3'd3));
    vq.push_back(v(1,0,1,8'h44,0,3'd3,3'd1,0, 0,1,8'h11,3'd4,1,0,1,0,3'd4));
    // full with both sides active: pop only, then simultaneous push/pop
    vq.push_back(v(1,0,1,8'h55,1,3'd3,3'd1,0, 1,1,8'h22,3'd3,0,0,1,0,3'd4));
    vq.push_back(v(1,0,1,8'h55,1,3'd3,3'd1,0, 1,1,8'h33,3'd3,0,0,1,0,3'd4));
    vq.push_back(v(1,0,0,8'h00,1,3'd3,3'd1,0, 1,1,8'h44,3'd2,0,0,0,0,3'd4));
    vq.push_back(v(1,0,0,8'h00,1,3'd3,3'd1,0, 1,1,8'h55,3'd1,0,0,0,0,3'd4));
    vq.push_back(v(1,0,0,8'h00,1,3'd3,3'd1,0, 1,0,8'h00,3'd0,0,1,0,1,3'd4));
    // clear watermark, fill 3, flush with both handshakes requested
    vq.push_back(v(1,0,0,8'h00,0,3'd3,3'd1,1, 1,0,8'h00,3'd0,0,1,0,1,3'd0));
    vq.push_back(v(1,0,1,8'hA1,0,3'd3,3'd1,0, 1,1,8'hA1,3'd1,0,0,0,0,3'd1));
    vq.push_back(v(1,0,1,8'hA2,0,3'd3,3'd1,0, 1,1,8'hA1,3'd2,0,0,0,0,3'd2));
    vq.push_back(v(1,0,1,8'hA3,0,3'd3,3'd1,0, 1,1,8'hA1,3'd3,0,0,1,0,3'd3));
    vq.push_back(v(1,1,1,8'hBB,1,3'd3,3'd1,0, 0,0,8'h00,3'd0,0,1,0,1,3'd3));
    vq.push_back(v(1,0,0,8'h00,0,3'd3,3'd1,0, 1,0,8'h00,3'd0,0,1,0,1,3'd3));
    // runtime threshold changes at stored=2
    vq.push_back(v(1,0,1,8'hC1,0,3'd3,3'd1,0, 1,1,8'hC1,3'd1,0,0,0,0,3'd3));
    vq.push_back(v(1,0,1,8'hC2,0,3'd3,3'd1,0, 1,1,8'hC1,3'd2,0,0,0,0,3'd3));
    vq.push_back(v(1,0,0,8'h00,0,3'd2,3'd1,0, 1,1,8'hC1,3'd2,0,0,1,0,3'd3));
    vq.push_back(v(1,0,0,8'h00,0,3'd2,3'd4,0, 1,1,8'hC1,3'd2,0,0,1,1,3'd3));
    vq.push_back(v(1,0,0,8'h00,0,3'd5,3'd4,0, 1,1,8'hC1,3'd2,0,0,0,1,3'd3));
    vq.push_back(v(1,0,0,8'h00,0,3'd0,3'd0,0, 1,1,8'hC1,3'd2,0,0,1,0,3'd3));
    // watermark: reach 4, drain to 1, clear, push one
    vq.push_back(v(1,0,1,8'hD1,0,3'd3,3'd1,0, 1,1,8'hC1,3'd3,0,0,1,0,3'd3));
    vq.push_back(v(1,0,1,8'hD2,0,3'd3,3'd1,0, 0,1,8'hC1,3'd4,1,0,1,0,3'd4));
    vq.push_back(v(1,0,0,8'h00,1,3'd3,3'd1,0, 1,1,8'hC2,3'd3,0,0,1,0,3'd4));
    vq.push_back(v(1,0,0,8'h00,1,3'd3,3'd1,0, 1,1,8'hD1,3'd2,0,0,0,0,3'd4));
    vq.push_back(v(1,0,0,8'h00,1,3'd3,3'd1,0, 1,1,8'hD2,3'd1,0,0,0,0,3'd4));
    vq.push_back(v(1,0,0,8'h00,0,3'd3,3'd1,1, 1,1,8'hD2,3'd1,0,0,0,0,3'd1));
    vq.push_back(v(1,0,1,8'hE1,0,3'd3,3'd1,0, 1,1,8'hD2,3'd2,0,0,0,0,3'd2));
    // reset mid-stream, then confirm no stale word survives
    vq.push_back(v(0,0,1,8'hF1,0,3'd3,3'd1,0, 0,0,8'h00,3'd0,0,1,0,1,3'd0));
    vq.push_back(v(1,0,0,8'h00,0,3'd3,3'd1,0, 1,0,8'h00,3'd0,0,1,0,1,3'd0));
    vq.push_back(v(1,0,1,8'hF2,0,3'd3,3'd1,0, 1,1,8'hF2,3'd1,0,0,0,0,3'd1));
    vq.push_back(v(1,0,0,8'h00,1,3'd3,3'd1,0, 1,0,8'h00,3'd0,0,1,0,1,3'd1));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // No combinational path from wr_data; word appears exactly one edge later.
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b0;
    #1;
    check("no_comb_path", {11'd0, rd_valid, rd_data}, 20'd0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("wr_to_rd_latency", {11'd0, rd_valid, rd_data}, {11'd0, 1'b1, 8'h77});

    // Flush held for two cycles with a producer waiting, then released.
    @(negedge clk);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99; rd_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("flush_held", {14'd0, wr_ready, rd_valid, 1'b0, stored}, {14'd0, 1'b0, 1'b0, 1'b0, 3'd0});
    end
    @(negedge clk);
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    check("flush_release", {15'd0, wr_ready, empty, stored}, {15'd0, 1'b1, 1'b1, 3'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
